// File: rtl/golf_input_conditioner_if.sv
// rtl/golf_input_conditioner_if.sv - raw board inputs and conditioned gameplay controls
interface golf_input_conditioner_if;
    logic       btn_hit_raw;
    logic       btn_left_raw;
    logic       btn_right_raw;
    logic       btn_reset_raw;
    logic       vsync_in;
    logic [2:0] gameplay_state;
    logic       new_game;
    logic       charging_hit;
    logic       camera_pan_left;
    logic       camera_pan_right;
    logic       new_frame;
    logic [7:0] swing_count;

    modport master (
        output btn_hit_raw, btn_left_raw, btn_right_raw, btn_reset_raw, vsync_in, gameplay_state,
        input  new_game, charging_hit, camera_pan_left, camera_pan_right, new_frame, swing_count
    );

    modport slave (
        input  btn_hit_raw, btn_left_raw, btn_right_raw, btn_reset_raw, vsync_in, gameplay_state,
        output new_game, charging_hit, camera_pan_left, camera_pan_right, new_frame, swing_count
    );
endinterface

// File: rtl/golf_input_conditioner.sv
// rtl/golf_input_conditioner.sv - button sync/debounce, hit FSM, pan gating, frame and new-game pulses
module golf_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter bit VSYNC_POL       = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    golf_input_conditioner_if.slave bus
);
    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                 NUM_BTN  = 4;
    localparam int                 B_HIT    = 0;
    localparam int                 B_LEFT   = 1;
    localparam int                 B_RIGHT  = 2;
    localparam int                 B_RESET  = 3;

    typedef enum logic [1:0] {
        HIT_IDLE     = 2'd0,
        HIT_ARMED    = 2'd1,
        HIT_SWINGING = 2'd2,
        HIT_LOCKED   = 2'd3
    } hit_state_t;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_sync1;
    logic [NUM_BTN-1:0] btn_sync2;
    logic [NUM_BTN-1:0] btn_clean;
    logic [NUM_BTN-1:0] btn_clean_q;
    logic [CNT_W-1:0]   db_cnt [NUM_BTN];

    logic       vs_sync1;
    logic       vs_sync2;
    logic       vs_q;
    logic       frame_edge;

    hit_state_t hit_state_q;
    hit_state_t hit_state_d;
    logic       swing_done;
    logic       hit_rise;
    logic       reset_rise;
    logic       ball_at_rest;
    logic       ball_released;

    logic       new_game_q;
    logic       charging_q;
    logic       pan_left_q;
    logic       pan_right_q;
    logic       new_frame_q;
    logic [7:0] swing_count_q;

    assign btn_raw = {bus.btn_reset_raw, bus.btn_right_raw, bus.btn_left_raw, bus.btn_hit_raw};

    // A clean level only moves after the synced value has disagreed with it for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            btn_sync1   <= '0;
            btn_sync2   <= '0;
            btn_clean   <= '0;
            btn_clean_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            btn_sync1   <= btn_raw;
            btn_sync2   <= btn_sync1;
            btn_clean_q <= btn_clean;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (btn_sync2[i] == btn_clean[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    btn_clean[i] <= btn_sync2[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign hit_rise      = btn_clean[B_HIT] & ~btn_clean_q[B_HIT];
    assign reset_rise    = btn_clean[B_RESET] & ~btn_clean_q[B_RESET];
    assign ball_at_rest  = (bus.gameplay_state == 3'd1);
    assign ball_released = (bus.gameplay_state == 3'd0) || (bus.gameplay_state == 3'd4) ||
                           (bus.gameplay_state == 3'd5) || (bus.gameplay_state == 3'd6);

    always_comb begin
        hit_state_d = hit_state_q;
        swing_done  = 1'b0;
        case (hit_state_q)
            HIT_IDLE: begin
                if (!btn_clean[B_HIT]) begin
                    hit_state_d = HIT_ARMED;
                end
            end
            HIT_ARMED: begin
                // A press while the ball is not at rest is consumed here; only a fresh press can swing.
                if (hit_rise && ball_at_rest) begin
                    hit_state_d = HIT_SWINGING;
                end
            end
            HIT_SWINGING: begin
                if (!btn_clean[B_HIT]) begin
                    hit_state_d = HIT_LOCKED;
                    swing_done  = 1'b1;
                end
            end
            HIT_LOCKED: begin
                if (ball_released) begin
                    hit_state_d = HIT_IDLE;
                end
            end
            default: hit_state_d = HIT_IDLE;
        endcase
        if (reset_rise) begin
            hit_state_d = HIT_IDLE;
            swing_done  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_state_q   <= HIT_IDLE;
            charging_q    <= 1'b0;
            swing_count_q <= '0;
            new_game_q    <= 1'b1;
        end else begin
            hit_state_q <= hit_state_d;
            charging_q  <= (hit_state_d == HIT_SWINGING);
            new_game_q  <= reset_rise;
            if (reset_rise) begin
                swing_count_q <= '0;
            end else if (swing_done && (swing_count_q != 8'hFF)) begin
                swing_count_q <= swing_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pan_left_q  <= 1'b0;
            pan_right_q <= 1'b0;
        end else begin
            pan_left_q  <= btn_clean[B_LEFT] & ~btn_clean[B_RIGHT] & (bus.gameplay_state != 3'd0);
            pan_right_q <= btn_clean[B_RIGHT] & ~btn_clean[B_LEFT] & (bus.gameplay_state != 3'd0);
        end
    end

    assign frame_edge = VSYNC_POL ? (vs_sync2 & ~vs_q) : (~vs_sync2 & vs_q);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vs_sync1    <= 1'b0;
            vs_sync2    <= 1'b0;
            vs_q        <= 1'b0;
            new_frame_q <= 1'b0;
        end else begin
            vs_sync1    <= bus.vsync_in;
            vs_sync2    <= vs_sync1;
            vs_q        <= vs_sync2;
            new_frame_q <= frame_edge;
        end
    end

    // new_game is asserted combinationally through reset so gameplay sees it before the first edge.
    assign bus.new_game         = rst_in | new_game_q;
    assign bus.charging_hit     = charging_q;
    assign bus.camera_pan_left  = pan_left_q;
    assign bus.camera_pan_right = pan_right_q;
    assign bus.new_frame        = new_frame_q;
    assign bus.swing_count      = swing_count_q;
endmodule
